// File: rtl/prio_enc_sched_pkg.sv
// prio_enc_sched_pkg: shared types and the request picker for priority_encoder_rr_sched
//  state_t  : RUN / DRAIN / DONE flush sequencer states
//  rr_pick  : index of the first set request at or above ptr, wrapping over n requesters
package prio_enc_sched_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  localparam int REQ_MAX = 32;
  localparam int PTR_W = 5;
  function automatic logic [PTR_W-1:0] rr_pick(input logic [REQ_MAX-1:0] req, input logic [PTR_W-1:0] ptr, input int n);
    int idx;
    rr_pick = ptr;
    // walk offsets from farthest to nearest so the nearest set request is the one that sticks
    for (int k = REQ_MAX - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && req[idx]) rr_pick = PTR_W'(idx);
    end
  endfunction
endpackage

// File: rtl/prio_enc_sched_tag_fifo.sv
// prio_enc_sched_tag_fifo: show-ahead FIFO holding requester IDs of requests in flight
//  clk, rst_n (async, active low)
//  push/din  : write an ID; accepted when not full, or when full together with pop
//  pop/dout  : dout shows the oldest ID; pop removes it when not empty
//  full/empty: occupancy flags
module prio_enc_sched_tag_fifo #(
  parameter int W = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign do_pop = pop && !empty;
  // when full, the slot being read this cycle is the one freed for the incoming ID
  assign do_push = push && (!full || pop);
  assign dout = mem[rd];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= (wr == AW'(DEPTH - 1)) ? '0 : wr + 1'b1;
      if (do_pop) rd <= (rd == AW'(DEPTH - 1)) ? '0 : rd + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= din;
  end
endmodule

// File: rtl/priority_encoder_rr_sched.sv
// priority_encoder_rr_sched: shares one priority encoder between REQ_N requesters
//  clk_i, arst_n_i (async, active low)
//  req_data_i/req_val_i/req_ready_o : per-requester request channel, ready one-hot or zero
//  enc_data_o/enc_data_val_o        : to encoder input (registered)
//  enc_data_left_i/right_i/val_i    : from encoder output
//  resp_left_o/right_o/id_o/val_o   : encoder result tagged with requester ID (registered)
//  flush_i/flush_done_o             : stop granting, pulse when everything in flight has returned
//  err_o                            : sticky, encoder result arrived with nothing outstanding
//  Build option PRIO_ENC_SCHED_STRICT_PRIO_EN: fixed priority (lowest index wins) instead of round-robin.
module priority_encoder_rr_sched
  import prio_enc_sched_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REQ_N = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                       clk_i,
  input  logic                       arst_n_i,
  input  logic [REQ_N*DATA_W-1:0]    req_data_i,
  input  logic [REQ_N-1:0]           req_val_i,
  output logic [REQ_N-1:0]           req_ready_o,
  output logic [DATA_W-1:0]          enc_data_o,
  output logic                       enc_data_val_o,
  input  logic [DATA_W-1:0]          enc_data_left_i,
  input  logic [DATA_W-1:0]          enc_data_right_i,
  input  logic                       enc_data_val_i,
  output logic [DATA_W-1:0]          resp_left_o,
  output logic [DATA_W-1:0]          resp_right_o,
  output logic [$clog2(REQ_N)-1:0]   resp_id_o,
  output logic                       resp_val_o,
  input  logic                       flush_i,
  output logic                       flush_done_o,
  output logic                       err_o
);
  localparam int ID_W = $clog2(REQ_N);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  state_t state, state_nxt;
  logic [ID_W-1:0] ptr, grant_id, tag_id;
  logic [CNT_W-1:0] outstanding, outstanding_nxt;
  logic can_grant, accept, pop, fifo_full, fifo_empty;
  // a returning result frees a slot in the same cycle, so a full scheduler may still grant;
  // ready is also forced low while reset is asserted so every output reads 0 immediately
  assign can_grant = arst_n_i && state == RUN && (!fifo_full || enc_data_val_i);
  assign grant_id = ID_W'(rr_pick(REQ_MAX'(req_val_i), PTR_W'(ptr), REQ_N));
  assign req_ready_o = (can_grant && |req_val_i) ? REQ_N'(1) << grant_id : '0;
  assign accept = |(req_val_i & req_ready_o);
  assign pop = enc_data_val_i && !fifo_empty;
  assign outstanding_nxt = outstanding + CNT_W'(accept) - CNT_W'(pop);
  assign flush_done_o = state == DONE;
  prio_enc_sched_tag_fifo #(.W(ID_W), .DEPTH(MAX_OUT)) u_tag_fifo (
    .clk(clk_i),
    .rst_n(arst_n_i),
    .push(accept),
    .din(grant_id),
    .pop(pop),
    .dout(tag_id),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  // DRAIN looks at the post-update count so a response landing this cycle completes the drain
  always_comb begin
    state_nxt = state;
    if (state == RUN) state_nxt = flush_i ? DRAIN : RUN;
    else if (state == DRAIN) state_nxt = (outstanding_nxt == '0) ? DONE : DRAIN;
    else state_nxt = flush_i ? DRAIN : RUN;
  end
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state <= RUN;
      ptr <= '0;
      outstanding <= '0;
      enc_data_o <= '0;
      enc_data_val_o <= 1'b0;
      resp_left_o <= '0;
      resp_right_o <= '0;
      resp_id_o <= '0;
      resp_val_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      outstanding <= outstanding_nxt;
      enc_data_val_o <= accept;
      if (accept) enc_data_o <= req_data_i[grant_id*DATA_W +: DATA_W];
`ifdef PRIO_ENC_SCHED_STRICT_PRIO_EN
      ptr <= '0;
`else
      if (accept) ptr <= (grant_id == ID_W'(REQ_N - 1)) ? '0 : grant_id + 1'b1;
`endif
      resp_val_o <= pop;
      if (pop) begin
        resp_left_o <= enc_data_left_i;
        resp_right_o <= enc_data_right_i;
        resp_id_o <= tag_id;
      end
      if (enc_data_val_i && fifo_empty) err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_priority_encoder_rr_sched.sv
// tb_priority_encoder_rr_sched: randomized bench with a queue-based reference model and encoder model
module tb_priority_encoder_rr_sched;
  localparam int DATA_W = 16;
  localparam int REQ_N = 4;
  localparam int MAX_OUT = 4;
  localparam int ID_W = 2;
  localparam int M_RUN = 0;
  localparam int M_DRAIN = 1;
  localparam int M_DONE = 2;
  logic clk = 1'b0;
  logic arst_n_i = 1'b0;
  logic [REQ_N*DATA_W-1:0] req_data_i = '0;
  logic [REQ_N-1:0] req_val_i = '0;
  logic [REQ_N-1:0] req_ready_o;
  logic [DATA_W-1:0] enc_data_o;
  logic enc_data_val_o;
  logic [DATA_W-1:0] enc_data_left_i = '0;
  logic [DATA_W-1:0] enc_data_right_i = '0;
  logic enc_data_val_i = 1'b0;
  logic [DATA_W-1:0] resp_left_o, resp_right_o;
  logic [ID_W-1:0] resp_id_o;
  logic resp_val_o;
  logic flush_i = 1'b0;
  logic flush_done_o;
  logic err_o;
  always #5 clk = ~clk;
  priority_encoder_rr_sched #(.DATA_W(DATA_W), .REQ_N(REQ_N), .MAX_OUT(MAX_OUT)) dut (
    .clk_i(clk),
    .arst_n_i(arst_n_i),
    .req_data_i(req_data_i),
    .req_val_i(req_val_i),
    .req_ready_o(req_ready_o),
    .enc_data_o(enc_data_o),
    .enc_data_val_o(enc_data_val_o),
    .enc_data_left_i(enc_data_left_i),
    .enc_data_right_i(enc_data_right_i),
    .enc_data_val_i(enc_data_val_i),
    .resp_left_o(resp_left_o),
    .resp_right_o(resp_right_o),
    .resp_id_o(resp_id_o),
    .resp_val_o(resp_val_o),
    .flush_i(flush_i),
    .flush_done_o(flush_done_o),
    .err_o(err_o)
  );
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int lat = 1;
  bit stall = 0;
  bit inj = 0;
  int m_ptr = 0;
  int m_phase = M_RUN;
  int qid[$];
  logic [DATA_W-1:0] qdat[$];
  logic [DATA_W-1:0] eq_dat[$];
  int eq_due[$];
  logic [DATA_W-1:0] exp_enc_data = '0, exp_left = '0, exp_right = '0;
  int exp_id = 0;
  bit exp_enc_val = 0, exp_rval = 0, exp_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [DATA_W-1:0] msb1h(input logic [DATA_W-1:0] d);
    for (int i = DATA_W - 1; i >= 0; i--) if (d[i]) return DATA_W'(1) << i;
    return '0;
  endfunction
  function automatic logic [DATA_W-1:0] lsb1h(input logic [DATA_W-1:0] d);
    return d & (~d + 1'b1);
  endfunction
  function automatic int pick(input logic [REQ_N-1:0] v, input int p);
    int s;
`ifdef PRIO_ENC_SCHED_STRICT_PRIO_EN
    s = 0;
`else
    s = p;
`endif
    for (int k = 0; k < REQ_N; k++) if (v[(s + k) % REQ_N]) return (s + k) % REQ_N;
    return -1;
  endfunction
  task automatic reset_model();
    qid.delete();
    qdat.delete();
    eq_dat.delete();
    eq_due.delete();
    m_ptr = 0;
    m_phase = M_RUN;
    exp_enc_data = '0;
    exp_left = '0;
    exp_right = '0;
    exp_id = 0;
    exp_enc_val = 0;
    exp_rval = 0;
    exp_err = 0;
  endtask
  task automatic cycle();
    int g;
    logic [DATA_W-1:0] d;
    chk("enc_data_val", 64'(enc_data_val_o), 64'(exp_enc_val));
    if (exp_enc_val) chk("enc_data", 64'(enc_data_o), 64'(exp_enc_data));
    chk("resp_val", 64'(resp_val_o), 64'(exp_rval));
    if (exp_rval) begin
      chk("resp_id", 64'(resp_id_o), 64'(exp_id));
      chk("resp_left", 64'(resp_left_o), 64'(exp_left));
      chk("resp_right", 64'(resp_right_o), 64'(exp_right));
    end
    chk("err", 64'(err_o), 64'(exp_err));
    if (exp_enc_val) begin
      eq_dat.push_back(exp_enc_data);
      eq_due.push_back(cyc + lat);
    end
    if (inj) begin
      enc_data_val_i = 1'b1;
      enc_data_left_i = DATA_W'($urandom);
      enc_data_right_i = DATA_W'($urandom);
    end else if (!stall && eq_due.size() > 0 && eq_due[0] <= cyc) begin
      d = eq_dat.pop_front();
      void'(eq_due.pop_front());
      enc_data_val_i = 1'b1;
      enc_data_left_i = msb1h(d);
      enc_data_right_i = lsb1h(d);
    end else begin
      enc_data_val_i = 1'b0;
      enc_data_left_i = DATA_W'($urandom);
      enc_data_right_i = DATA_W'($urandom);
    end
    #1;
    g = (m_phase == M_RUN && (qid.size() < MAX_OUT || enc_data_val_i)) ? pick(req_val_i, m_ptr) : -1;
    chk("req_ready", 64'(req_ready_o), g < 0 ? 64'd0 : 64'd1 << g);
    chk("flush_done", 64'(flush_done_o), 64'(m_phase == M_DONE));
    exp_rval = 0;
    if (enc_data_val_i) begin
      if (qid.size() > 0) begin
        exp_id = qid.pop_front();
        d = qdat.pop_front();
        exp_left = msb1h(d);
        exp_right = lsb1h(d);
        exp_rval = 1;
      end else exp_err = 1;
    end
    exp_enc_val = g >= 0;
    if (g >= 0) begin
      exp_enc_data = req_data_i[g*DATA_W +: DATA_W];
      qid.push_back(g);
      qdat.push_back(exp_enc_data);
      m_ptr = (g + 1) % REQ_N;
    end
    if (m_phase == M_RUN) m_phase = flush_i ? M_DRAIN : M_RUN;
    else if (m_phase == M_DRAIN) m_phase = qid.size() == 0 ? M_DONE : M_DRAIN;
    else m_phase = flush_i ? M_DRAIN : M_RUN;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask
  initial begin
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 64'(req_ready_o), 64'd0);
    chk("reset_resp_val", 64'(resp_val_o), 64'd0);
    arst_n_i = 1'b1;
    // all requesters valid, data = index + 1
    req_val_i = 4'hF;
    req_data_i = {16'd4, 16'd3, 16'd2, 16'd1};
    run(40);
    // lone requester 2
    req_val_i = 4'b0100;
    req_data_i = {16'h0, 16'h0810, 16'h0, 16'h0};
    run(10);
    req_val_i = '0;
    run(6);
    // encoder stalled: fill to MAX_OUT, then release while still requesting
    stall = 1;
    req_val_i = 4'hF;
    req_data_i = {$urandom, $urandom};
    run(8);
    stall = 0;
    run(10);
    req_val_i = '0;
    run(8);
    // flush with three in flight
    stall = 1;
    req_val_i = 4'hF;
    run(3);
    req_val_i = 4'hF;
    flush_i = 1'b1;
    run(3);
    stall = 0;
    run(4);
    flush_i = 1'b0;
    run(6);
    // underflow injection with nothing outstanding
    req_val_i = '0;
    run(4);
    inj = 1;
    run(1);
    inj = 0;
    run(5);
    // randomized traffic, 1-cycle then 3-cycle encoder
    for (int i = 0; i < 800; i++) begin
      if (i == 400) lat = 3;
      req_val_i = REQ_N'($urandom);
      req_data_i = {$urandom, $urandom};
      stall = $urandom_range(0, 7) == 0;
      flush_i = $urandom_range(0, 15) == 0;
      cycle();
    end
    stall = 0;
    flush_i = 1'b0;
    // reset in the middle of traffic
    req_val_i = 4'hF;
    run(5);
    arst_n_i = 1'b0;
    enc_data_val_i = 1'b0;
    #1;
    chk("arst_ready", 64'(req_ready_o), 64'd0);
    chk("arst_enc_val", 64'(enc_data_val_o), 64'd0);
    chk("arst_enc_data", 64'(enc_data_o), 64'd0);
    chk("arst_resp_val", 64'(resp_val_o), 64'd0);
    chk("arst_resp_left", 64'(resp_left_o), 64'd0);
    chk("arst_resp_right", 64'(resp_right_o), 64'd0);
    chk("arst_resp_id", 64'(resp_id_o), 64'd0);
    chk("arst_flush_done", 64'(flush_done_o), 64'd0);
    chk("arst_err", 64'(err_o), 64'd0);
    reset_model();
    @(posedge clk);
    #1;
    arst_n_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      req_val_i = REQ_N'($urandom);
      req_data_i = {$urandom, $urandom};
      stall = $urandom_range(0, 5) == 0;
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
